// File: rtl/huffman_pkg.sv
// Shared types and helpers for the parametrised Huffman coder: FSM encodings,
// the merge-slot record and the slot ordering rule used by the min-2 scanner.
package huffman_pkg;

    localparam int GID_W  = 5;
    localparam int IDX_W  = 5;
    localparam int LEN_W  = 5;
    localparam int SCNT_W = 32;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [SCNT_W-1:0] count;
        logic [GID_W-1:0]  gid;
        logic              active;
    } slot_t;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // Lower count wins; on equal counts the larger group id is the smaller key.
    function automatic logic key_less(input slot_t a, input slot_t b);
        return (a.count < b.count) || ((a.count == b.count) && (a.gid > b.gid));
    endfunction

endpackage

// File: rtl/huffman_min2_scan.sv
// Sequential smallest / second-smallest tracker: one slot per enabled cycle,
// restarted by start on the first slot of each scan.
module huffman_min2_scan
    import huffman_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  slot_t            slot_in,
    input  logic [IDX_W-1:0] idx_in,
    output slot_t            a_slot,
    output slot_t            b_slot,
    output logic [IDX_W-1:0] a_idx,
    output logic [IDX_W-1:0] b_idx
);

    logic a_valid_reg;
    logic b_valid_reg;
    logic cur_a_valid;
    logic cur_b_valid;
    logic take_a;
    logic take_b;

    always_comb begin
        cur_a_valid = start ? 1'b0 : a_valid_reg;
        cur_b_valid = start ? 1'b0 : b_valid_reg;
        take_a      = 1'b0;
        take_b      = 1'b0;
        if (en && slot_in.active) begin
            if (!cur_a_valid || key_less(slot_in, a_slot)) begin
                take_a = 1'b1;
            end else if (!cur_b_valid || key_less(slot_in, b_slot)) begin
                take_b = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_slot      <= '0;
            b_slot      <= '0;
            a_idx       <= '0;
            b_idx       <= '0;
            a_valid_reg <= 1'b0;
            b_valid_reg <= 1'b0;
        end else if (en) begin
            if (take_a) begin
                b_slot      <= a_slot;
                b_idx       <= a_idx;
                b_valid_reg <= cur_a_valid;
                a_slot      <= slot_in;
                a_idx       <= idx_in;
                a_valid_reg <= 1'b1;
            end else if (take_b) begin
                b_slot      <= slot_in;
                b_idx       <= idx_in;
                b_valid_reg <= 1'b1;
                a_valid_reg <= cur_a_valid;
            end else begin
                a_valid_reg <= cur_a_valid;
                b_valid_reg <= cur_b_valid;
            end
        end
    end

endmodule

// File: rtl/huffman_param_coder.sv
// Frame histogram plus Huffman code construction by repeated two-minimum merge;
// publishes per-symbol counts, then per-symbol right-aligned codes and length masks.
module huffman_param_coder
    import huffman_pkg::*;
#(
    parameter int NSYM   = 6,
    parameter int NSAMP  = 100,
    parameter int CODE_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gray_valid,
    input  logic [DATA_W-1:0]        gray_data,
    output logic                     gray_ready,
    output logic                     cnt_valid,
    output logic [NSYM*clog2(NSAMP+1)-1:0] cnt_o,
    output logic                     err_sym,
    output logic                     code_valid,
    output logic [NSYM*CODE_W-1:0]   hc_o,
    output logic [NSYM*CODE_W-1:0]   m_o
);

    localparam int CNT_W = clog2(NSAMP + 1);

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  samp_reg;
    logic [CNT_W-1:0]  hist_reg [NSYM];
    logic [CNT_W-1:0]  hist_next [NSYM];
    logic              err_reg;
    logic              err_next;
    logic              accept;
    logic              last_accept;
    logic              sym_ok;

    slot_t             slot_reg [NSYM];
    slot_t             scan_slot;
    logic [GID_W-1:0]  gid_reg [NSYM];
    logic [GID_W-1:0]  gid_next [NSYM];
    logic [LEN_W-1:0]  len_reg [NSYM];
    logic [LEN_W-1:0]  len_next [NSYM];
    logic [CODE_W-1:0] code_reg [NSYM];
    logic [CODE_W-1:0] code_next [NSYM];
    logic [IDX_W-1:0]  scan_idx_reg;
    logic [GID_W-1:0]  merge_num_reg;
    logic [GID_W-1:0]  new_gid;

    slot_t             a_slot;
    slot_t             b_slot;
    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  b_idx;

    logic              cnt_valid_reg;
    logic              err_sym_reg;
    logic              code_valid_reg;
    logic [CNT_W-1:0]  cnt_out_reg [NSYM];
    logic [CODE_W-1:0] hc_reg [NSYM];
    logic [CODE_W-1:0] m_reg [NSYM];

    assign gray_ready  = (state_reg == ST_LOAD);
    assign accept      = gray_valid && gray_ready;
    assign last_accept = accept && (samp_reg == CNT_W'(NSAMP - 1));
    assign sym_ok      = (gray_data != '0) && (32'(gray_data) <= 32'(NSYM));
    assign new_gid     = GID_W'(NSYM) + merge_num_reg;

    assign cnt_valid  = cnt_valid_reg;
    assign err_sym    = err_sym_reg;
    assign code_valid = code_valid_reg;

    for (genvar gi = 0; gi < NSYM; gi++) begin : g_out
        assign cnt_o[gi*CNT_W +: CNT_W]  = cnt_out_reg[gi];
        assign hc_o[gi*CODE_W +: CODE_W] = hc_reg[gi];
        assign m_o[gi*CODE_W +: CODE_W]  = m_reg[gi];
    end

    always_comb begin
        err_next  = err_reg | (accept & ~sym_ok);
        scan_slot = '0;
        for (int s = 0; s < NSYM; s++) begin
            hist_next[s] = hist_reg[s];
            if (accept && (32'(gray_data) == 32'(s + 1))) begin
                hist_next[s] = hist_reg[s] + CNT_W'(1);
            end
            if (IDX_W'(s) == scan_idx_reg) begin
                scan_slot = slot_reg[s];
            end
        end
    end

    // Group A members get a 1 at their current length, group B a 0; each new bit
    // lands above the existing ones so it ends up as the code MSB.
    always_comb begin
        for (int s = 0; s < NSYM; s++) begin
            code_next[s] = code_reg[s];
            len_next[s]  = len_reg[s];
            gid_next[s]  = gid_reg[s];
            if (state_reg == ST_MERGE) begin
                if (gid_reg[s] == a_slot.gid) begin
                    code_next[s] = code_reg[s] | (CODE_W'(1) << len_reg[s]);
                    len_next[s]  = len_reg[s] + LEN_W'(1);
                    gid_next[s]  = new_gid;
                end else if (gid_reg[s] == b_slot.gid) begin
                    code_next[s] = code_reg[s] & ~(CODE_W'(1) << len_reg[s]);
                    len_next[s]  = len_reg[s] + LEN_W'(1);
                    gid_next[s]  = new_gid;
                end
            end
        end
    end

    huffman_min2_scan u_scan (
        .clk     (clk),
        .reset   (reset),
        .en      (state_reg == ST_SCAN),
        .start   (scan_idx_reg == '0),
        .slot_in (scan_slot),
        .idx_in  (scan_idx_reg),
        .a_slot  (a_slot),
        .b_slot  (b_slot),
        .a_idx   (a_idx),
        .b_idx   (b_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_LOAD;
            samp_reg       <= '0;
            err_reg        <= 1'b0;
            cnt_valid_reg  <= 1'b0;
            err_sym_reg    <= 1'b0;
            code_valid_reg <= 1'b0;
            scan_idx_reg   <= '0;
            merge_num_reg  <= '0;
            for (int s = 0; s < NSYM; s++) begin
                hist_reg[s]    <= '0;
                slot_reg[s]    <= '0;
                gid_reg[s]     <= '0;
                len_reg[s]     <= '0;
                code_reg[s]    <= '0;
                cnt_out_reg[s] <= '0;
                hc_reg[s]      <= '0;
                m_reg[s]       <= '0;
            end
        end else begin
            cnt_valid_reg  <= 1'b0;
            code_valid_reg <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    if (accept) begin
                        err_reg  <= err_next;
                        samp_reg <= samp_reg + CNT_W'(1);
                        for (int s = 0; s < NSYM; s++) begin
                            hist_reg[s] <= hist_next[s];
                        end
                    end
                    if (last_accept) begin
                        samp_reg      <= '0;
                        cnt_valid_reg <= 1'b1;
                        err_sym_reg   <= err_next;
                        scan_idx_reg  <= '0;
                        merge_num_reg <= '0;
                        state_reg     <= ST_SCAN;
                        for (int s = 0; s < NSYM; s++) begin
                            cnt_out_reg[s] <= hist_next[s];
                            slot_reg[s]    <= '{count: SCNT_W'(hist_next[s]), gid: GID_W'(s), active: 1'b1};
                            gid_reg[s]     <= GID_W'(s);
                            len_reg[s]     <= '0;
                            code_reg[s]    <= '0;
                        end
                    end
                end
                ST_SCAN: begin
                    scan_idx_reg <= scan_idx_reg + IDX_W'(1);
                    if (scan_idx_reg == IDX_W'(NSYM - 1)) begin
                        scan_idx_reg <= '0;
                        state_reg    <= ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    merge_num_reg <= merge_num_reg + GID_W'(1);
                    for (int s = 0; s < NSYM; s++) begin
                        code_reg[s] <= code_next[s];
                        len_reg[s]  <= len_next[s];
                        gid_reg[s]  <= gid_next[s];
                        if (IDX_W'(s) == a_idx) begin
                            slot_reg[s].count <= a_slot.count + b_slot.count;
                            slot_reg[s].gid   <= new_gid;
                        end
                        if (IDX_W'(s) == b_idx) begin
                            slot_reg[s].active <= 1'b0;
                        end
                    end
                    if (merge_num_reg == GID_W'(NSYM - 2)) begin
                        state_reg      <= ST_DONE;
                        code_valid_reg <= 1'b1;
                        for (int s = 0; s < NSYM; s++) begin
                            hc_reg[s] <= code_next[s];
                            m_reg[s]  <= (CODE_W'(1) << len_next[s]) - CODE_W'(1);
                        end
                    end else begin
                        state_reg <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_LOAD;
                    err_reg   <= 1'b0;
                    for (int s = 0; s < NSYM; s++) begin
                        hist_reg[s] <= '0;
                    end
                end
                default: state_reg <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_param_coder.sv
// Directed bench: a 4-symbol/8-sample coder and a default 6-symbol/100-sample coder
// driven with hand-worked frames; expected counts and codes are literal tables.
module tb_huffman_param_coder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        v4, r4, cv4, e4, codev4;
    logic [7:0]  d4;
    logic [15:0] cnt4;
    logic [31:0] hc4, m4;

    logic        v6, r6, cv6, e6, codev6;
    logic [7:0]  d6;
    logic [41:0] cnt6;
    logic [47:0] hc6, m6;

    int vectors = 0;
    int miscompares = 0;

    huffman_param_coder #(.NSYM(4), .NSAMP(8), .CODE_W(8), .DATA_W(8)) dut4 (
        .clk(clk), .reset(reset), .gray_valid(v4), .gray_data(d4), .gray_ready(r4),
        .cnt_valid(cv4), .cnt_o(cnt4), .err_sym(e4), .code_valid(codev4), .hc_o(hc4), .m_o(m4)
    );

    huffman_param_coder dut6 (
        .clk(clk), .reset(reset), .gray_valid(v6), .gray_data(d6), .gray_ready(r6),
        .cnt_valid(cv6), .cnt_o(cnt6), .err_sym(e6), .code_valid(codev6), .hc_o(hc6), .m_o(m6)
    );

    task automatic send4(input int s);
        @(negedge clk);
        v4 = 1'b1;
        d4 = 8'(s);
        @(posedge clk);
    endtask

    task automatic send6(input int s);
        @(negedge clk);
        v6 = 1'b1;
        d6 = 8'(s);
        @(posedge clk);
    endtask

    task automatic wait_code4(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = (codev4 === 1'b1);
        end
    endtask

    task automatic wait_code6(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = (codev6 === 1'b1);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; v4 = 1'b0; d4 = '0; v6 = 1'b0; d6 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (r4 !== 1'b1) begin miscompares++; $display("FAIL reset_ready4 got %b want 1", r4); end
        vectors++; if (cv4 !== 1'b0) begin miscompares++; $display("FAIL reset_cntv4 got %b want 0", cv4); end
        vectors++; if (e4 !== 1'b0) begin miscompares++; $display("FAIL reset_err4 got %b want 0", e4); end
        vectors++; if (codev4 !== 1'b0) begin miscompares++; $display("FAIL reset_codev4 got %b want 0", codev4); end
        vectors++; if (cnt4 !== '0) begin miscompares++; $display("FAIL reset_cnt4 got %h want 0", cnt4); end
        vectors++; if (hc4 !== '0 || m4 !== '0) begin miscompares++; $display("FAIL reset_code4 got hc=%h m=%h want 0", hc4, m4); end
        vectors++; if (r6 !== 1'b1) begin miscompares++; $display("FAIL reset_ready6 got %b want 1", r6); end
        vectors++; if (cv6 !== 1'b0 || codev6 !== 1'b0) begin miscompares++; $display("FAIL reset_valid6 got cntv=%b codev=%b want 0", cv6, codev6); end
        vectors++; if (cnt6 !== '0 || e6 !== 1'b0) begin miscompares++; $display("FAIL reset_cnt6 got cnt=%h err=%b want 0", cnt6, e6); end
        vectors++; if (hc6 !== '0 || m6 !== '0) begin miscompares++; $display("FAIL reset_code6 got hc=%h m=%h want 0", hc6, m6); end
        $display("reset: outputs cleared, ready4=%b ready6=%b", r4, r6);
    endtask

    task automatic test_small_frame;
        int syms[8]    = '{1, 1, 1, 1, 2, 2, 3, 4};
        int exp_cnt[4] = '{4, 2, 1, 1};
        int exp_hc[4]  = '{0, 2, 6, 7};
        int exp_m[4]   = '{1, 3, 7, 7};
        bit seen;
        for (int i = 0; i < 8; i++) send4(syms[i]);
        @(negedge clk);
        v4 = 1'b0;
        vectors++; if (cv4 !== 1'b1) begin miscompares++; $display("FAIL small_cntv got %b want 1", cv4); end
        vectors++; if (e4 !== 1'b0) begin miscompares++; $display("FAIL small_err got %b want 0", e4); end
        vectors++; if (r4 !== 1'b0) begin miscompares++; $display("FAIL small_ready_build got %b want 0", r4); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (cnt4[k*4 +: 4] !== 4'(exp_cnt[k])) begin miscompares++; $display("FAIL small_cnt sym%0d got %0d want %0d", k + 1, cnt4[k*4 +: 4], exp_cnt[k]); end
        end
        wait_code4(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL small_code_timeout got none want code_valid"); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (hc4[k*8 +: 8] !== 8'(exp_hc[k]) || m4[k*8 +: 8] !== 8'(exp_m[k])) begin
                miscompares++; $display("FAIL small_code sym%0d got hc=%0d m=%0d want hc=%0d m=%0d", k + 1, hc4[k*8 +: 8], m4[k*8 +: 8], exp_hc[k], exp_m[k]);
            end
        end
        vectors++; if (r4 !== 1'b0) begin miscompares++; $display("FAIL small_ready_done got %b want 0", r4); end
        @(negedge clk);
        vectors++; if (codev4 !== 1'b0 || r4 !== 1'b1) begin miscompares++; $display("FAIL small_after got codev=%b ready=%b want 0/1", codev4, r4); end
        $display("small: cnt=%h hc=%h m=%h", cnt4, hc4, m4);
    endtask

    task automatic test_single_sym;
        int exp_cnt[6] = '{0, 0, 100, 0, 0, 0};
        int exp_hc[6]  = '{2, 6, 0, 14, 30, 31};
        int exp_m[6]   = '{3, 7, 1, 15, 31, 31};
        bit seen;
        for (int i = 0; i < 100; i++) send6(3);
        @(negedge clk);
        v6 = 1'b0;
        vectors++; if (cv6 !== 1'b1 || e6 !== 1'b0) begin miscompares++; $display("FAIL single_cntv got cntv=%b err=%b want 1/0", cv6, e6); end
        for (int k = 0; k < 6; k++) begin
            vectors++; if (cnt6[k*7 +: 7] !== 7'(exp_cnt[k])) begin miscompares++; $display("FAIL single_cnt sym%0d got %0d want %0d", k + 1, cnt6[k*7 +: 7], exp_cnt[k]); end
        end
        wait_code6(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL single_code_timeout got none want code_valid"); end
        for (int k = 0; k < 6; k++) begin
            vectors++; if (hc6[k*8 +: 8] !== 8'(exp_hc[k]) || m6[k*8 +: 8] !== 8'(exp_m[k])) begin
                miscompares++; $display("FAIL single_code sym%0d got hc=%0d m=%0d want hc=%0d m=%0d", k + 1, hc6[k*8 +: 8], m6[k*8 +: 8], exp_hc[k], exp_m[k]);
            end
        end
        $display("single: cnt=%h hc=%h m=%h", cnt6, hc6, m6);
    endtask

    task automatic test_invalid_hold;
        int exp_cnt[6] = '{17, 17, 16, 17, 15, 16};
        bit seen;
        for (int i = 0; i < 100; i++) begin
            send6(i == 10 ? 0 : (i == 50 ? 9 : (i % 6) + 1));
            if (i == 98) begin
                #1;
                vectors++; if (cv6 !== 1'b0) begin miscompares++; $display("FAIL invalid_early_close got %b want 0", cv6); end
            end
        end
        @(negedge clk);
        d6 = 8'd1;
        vectors++; if (cv6 !== 1'b1) begin miscompares++; $display("FAIL invalid_cntv got %b want 1", cv6); end
        vectors++; if (e6 !== 1'b1) begin miscompares++; $display("FAIL invalid_err got %b want 1", e6); end
        for (int k = 0; k < 6; k++) begin
            vectors++; if (cnt6[k*7 +: 7] !== 7'(exp_cnt[k])) begin miscompares++; $display("FAIL invalid_cnt sym%0d got %0d want %0d", k + 1, cnt6[k*7 +: 7], exp_cnt[k]); end
        end
        wait_code6(seen);
        v6 = 1'b0;
        vectors++; if (!seen) begin miscompares++; $display("FAIL invalid_code_timeout got none want code_valid"); end
        $display("invalid: cnt=%h err=%b", cnt6, e6);
    endtask

    task automatic test_back_to_back;
        int fa[8]       = '{1, 1, 1, 1, 2, 2, 3, 4};
        int fb[8]       = '{4, 4, 4, 4, 4, 3, 3, 2};
        int exp_cnt[4]  = '{0, 1, 2, 5};
        int exp_hc[4]   = '{7, 6, 2, 0};
        int exp_m[4]    = '{7, 7, 3, 1};
        int exp6_hc[6]  = '{2, 6, 0, 14, 30, 31};
        bit seen;
        // d6 follows the invalid/held frame directly: no leftover counts or err
        for (int i = 0; i < 100; i++) send6(3);
        @(negedge clk);
        v6 = 1'b0;
        vectors++; if (e6 !== 1'b0) begin miscompares++; $display("FAIL b2b6_err got %b want 0", e6); end
        vectors++; if (cnt6 !== {7'd0, 7'd0, 7'd0, 7'd100, 7'd0, 7'd0}) begin miscompares++; $display("FAIL b2b6_cnt got %h want %h", cnt6, {7'd0, 7'd0, 7'd0, 7'd100, 7'd0, 7'd0}); end
        wait_code6(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL b2b6_code_timeout got none want code_valid"); end
        for (int k = 0; k < 6; k++) begin
            vectors++; if (hc6[k*8 +: 8] !== 8'(exp6_hc[k])) begin miscompares++; $display("FAIL b2b6_hc sym%0d got %0d want %0d", k + 1, hc6[k*8 +: 8], exp6_hc[k]); end
        end
        $display("b2b6: cnt=%h hc=%h", cnt6, hc6);

        for (int i = 0; i < 8; i++) send4(fa[i]);
        @(negedge clk);
        v4 = 1'b0;
        wait_code4(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL b2b4_a_timeout got none want code_valid"); end
        for (int i = 0; i < 8; i++) send4(fb[i]);
        @(negedge clk);
        v4 = 1'b0;
        vectors++; if (cv4 !== 1'b1 || e4 !== 1'b0) begin miscompares++; $display("FAIL b2b4_cntv got cntv=%b err=%b want 1/0", cv4, e4); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (cnt4[k*4 +: 4] !== 4'(exp_cnt[k])) begin miscompares++; $display("FAIL b2b4_cnt sym%0d got %0d want %0d", k + 1, cnt4[k*4 +: 4], exp_cnt[k]); end
        end
        wait_code4(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL b2b4_b_timeout got none want code_valid"); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (hc4[k*8 +: 8] !== 8'(exp_hc[k]) || m4[k*8 +: 8] !== 8'(exp_m[k])) begin
                miscompares++; $display("FAIL b2b4_code sym%0d got hc=%0d m=%0d want hc=%0d m=%0d", k + 1, hc4[k*8 +: 8], m4[k*8 +: 8], exp_hc[k], exp_m[k]);
            end
        end
        $display("b2b4: cnt=%h hc=%h m=%h", cnt4, hc4, m4);
    endtask

    task automatic test_reset_mid_scan;
        int fa[8]      = '{1, 1, 1, 1, 2, 2, 3, 4};
        int fb[8]      = '{4, 4, 4, 4, 4, 3, 3, 2};
        int exp_hc[4]  = '{7, 6, 2, 0};
        bit seen;
        for (int i = 0; i < 8; i++) send4(fa[i]);
        @(negedge clk);
        v4 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (cnt4 !== '0 || cv4 !== 1'b0 || e4 !== 1'b0) begin miscompares++; $display("FAIL midreset_cnt got cnt=%h cntv=%b err=%b want 0", cnt4, cv4, e4); end
        vectors++; if (hc4 !== '0 || m4 !== '0 || codev4 !== 1'b0) begin miscompares++; $display("FAIL midreset_code got hc=%h m=%h codev=%b want 0", hc4, m4, codev4); end
        vectors++; if (r4 !== 1'b1) begin miscompares++; $display("FAIL midreset_ready got %b want 1", r4); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) send4(fb[i]);
        @(negedge clk);
        v4 = 1'b0;
        vectors++; if (cnt4 !== {4'd5, 4'd2, 4'd1, 4'd0}) begin miscompares++; $display("FAIL midreset_fresh_cnt got %h want %h", cnt4, {4'd5, 4'd2, 4'd1, 4'd0}); end
        wait_code4(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL midreset_code_timeout got none want code_valid"); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (hc4[k*8 +: 8] !== 8'(exp_hc[k])) begin miscompares++; $display("FAIL midreset_hc sym%0d got %0d want %0d", k + 1, hc4[k*8 +: 8], exp_hc[k]); end
        end
        $display("midreset: cnt=%h hc=%h m=%h", cnt4, hc4, m4);
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_single_sym();
        test_invalid_hold();
        test_back_to_back();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
